wb_burst_splitter: RTL and testbench

Converts a burst Wishbone request from the L1 cache / bus arbiter master port (address, burst length, burst-ready) into a sequence of single-beat classic Wishbone transactions for a slave that does not support bursts. It sits directly downstream of the arbiter's data-side master port and upstream of the SoC data mux. Each beat's address increments by 4, and read data is buffered in a one-entry hold register until the master signals burst-ready. A per-beat timeout guards against a hung slave.

---
 rtl/wb_burst_splitter.sv | 157 +++++++++++++++
 tb/tb_wb_burst_splitter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_splitter.sv
// wb_burst_splitter
// Breaks a Wishbone burst request from the arbiter's data-side master port
// into a series of single-beat classic Wishbone cycles for a slave that
// cannot burst. Each beat's address advances by 4. Read data is held in
// m_dat_o until the master raises m_bry_i. A per-beat watchdog abandons
// the burst if the slave never acknowledges.
module wb_burst_splitter #(
    parameter int unsigned TIMEOUT = 255   // REQ cycles without ack before abort, 1..255
) (
    input  logic        clk,
    input  logic        reset,
    // master (burst) side
    input  logic        m_cyc_i,
    input  logic        m_stb_i,
    input  logic        m_we_i,
    input  logic [31:0] m_adr_i,
    input  logic [9:0]  m_bl_i,
    input  logic        m_bry_i,
    input  logic [31:0] m_dat_i,
    input  logic [3:0]  m_sel_i,
    output logic        m_ack_o,
    output logic [31:0] m_dat_o,
    output logic        m_err_o,
    // slave (classic single-beat) side
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic [9:0] beats_reg;     // beats remaining, including the current one
    logic [7:0] tmo_cnt_reg;   // REQ cycles spent on the current beat

    logic start;
    logic last_beat;
    logic tmo_hit;

    assign start     = (state_reg == ST_IDLE) && m_cyc_i && m_stb_i;
    assign last_beat = (beats_reg == 10'd1);

    // Writes complete as soon as the slave has taken the data; reads wait
    // for the master to accept the held word. An abort suppresses the ack.
    assign m_ack_o = (state_reg == ST_RESP) && m_cyc_i && (s_we_o || m_bry_i);

    // The watchdog only fires when neither an abort nor a slave ack
    // happens in the same cycle, which gives both of those priority.
    assign tmo_hit = (state_reg == ST_REQ) && m_cyc_i && !s_ack_i
                     && (tmo_cnt_reg == TMO_LIMIT);

    // Next-state selection for the IDLE/REQ/RESP sequencer.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!m_cyc_i) begin
                    state_next = ST_IDLE;
                end else if (s_ack_i) begin
                    state_next = ST_RESP;
                end else if (tmo_hit) begin
                    state_next = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (!m_cyc_i) begin
                    state_next = ST_IDLE;
                end else if (m_ack_o) begin
                    state_next = last_beat ? ST_IDLE : ST_REQ;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, slave-side controls, beat bookkeeping and the read hold register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            beats_reg   <= 10'd0;
            tmo_cnt_reg <= 8'd0;
            m_dat_o     <= 32'd0;
            m_err_o     <= 1'b0;
            s_cyc_o     <= 1'b0;
            s_stb_o     <= 1'b0;
            s_we_o      <= 1'b0;
            s_adr_o     <= 32'd0;
            s_dat_o     <= 32'd0;
            s_sel_o     <= 4'd0;
        end else begin
            state_reg <= state_next;
            // Slave controls are registered copies of the next state, so
            // cyc stays up from the first REQ through the final RESP.
            s_cyc_o   <= (state_next != ST_IDLE);
            s_stb_o   <= (state_next == ST_REQ);
            m_err_o   <= tmo_hit;

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        s_adr_o     <= m_adr_i;
                        s_we_o      <= m_we_i;
                        s_dat_o     <= m_dat_i;
                        s_sel_o     <= m_sel_i;
                        beats_reg   <= (m_bl_i == 10'd0) ? 10'd1 : m_bl_i;
                        tmo_cnt_reg <= 8'd0;
                    end
                end
                ST_REQ: begin
                    if (m_cyc_i) begin
                        if (s_ack_i) begin
                            if (!s_we_o) begin
                                m_dat_o <= s_dat_i;
                            end
                        end else if (!tmo_hit) begin
                            tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
                        end
                    end
                end
                ST_RESP: begin
                    if (m_ack_o && !last_beat) begin
                        beats_reg   <= beats_reg - 10'd1;
                        s_adr_o     <= s_adr_o + 32'd4;
                        s_dat_o     <= m_dat_i;
                        s_sel_o     <= m_sel_i;
                        tmo_cnt_reg <= 8'd0;
                    end
                end
                default: begin
                end
            endcase

            // Direction is only meaningful inside a burst.
            if (state_next == ST_IDLE) begin
                s_we_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_burst_splitter.sv
// tb_wb_burst_splitter
// Table of burst records driven through the splitter with a cycle-accurate
// slave, plus hand-written abort, timeout and mid-burst reset sequences.
// Expected beat addresses/data are queued when a burst is issued and popped
// as each beat appears on the slave side.
module tb_wb_burst_splitter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m_cyc_i = 1'b0;
    logic        m_stb_i = 1'b0;
    logic        m_we_i = 1'b0;
    logic [31:0] m_adr_i = 32'd0;
    logic [9:0]  m_bl_i = 10'd0;
    logic        m_bry_i = 1'b0;
    logic [31:0] m_dat_i = 32'd0;
    logic [3:0]  m_sel_i = 4'd0;
    logic        m_ack_o;
    logic [31:0] m_dat_o;
    logic        m_err_o;
    logic        s_cyc_o;
    logic        s_stb_o;
    logic        s_we_o;
    logic [31:0] s_adr_o;
    logic [31:0] s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_ack_i = 1'b0;
    logic [31:0] s_dat_i = 32'd0;

    wb_burst_splitter #(.TIMEOUT(255)) dut (
        .clk     (clk),
        .reset   (reset),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_we_i  (m_we_i),
        .m_adr_i (m_adr_i),
        .m_bl_i  (m_bl_i),
        .m_bry_i (m_bry_i),
        .m_dat_i (m_dat_i),
        .m_sel_i (m_sel_i),
        .m_ack_o (m_ack_o),
        .m_dat_o (m_dat_o),
        .m_err_o (m_err_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_ack_i (s_ack_i),
        .s_dat_i (s_dat_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [9:0]  bl;
        int          wait_cyc;     // slave wait states before each ack
        logic [31:0] dbase;        // beat i data = dbase + i*dstep
        logic [31:0] dstep;
        logic [3:0]  sel;          // odd beats use sel ^ sel_x
        logic [3:0]  sel_x;
        int          stall_beat;   // beat index with m_bry_i low, -1 = none
        int          stall_len;
        int          exp_beats;    // expected m_ack_o pulses
        logic [31:0] exp_last_adr; // expected address of the final beat
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] adr_q [$];
    logic [31:0] dat_q [$];
    logic [31:0] rd_hold = 32'd0;
    int          tests = 0;
    int          fails = 0;
    int          ack_count = 0;

    // Count every cycle in which a beat completes toward the master.
    always @(posedge clk) begin
        if (m_ack_o) begin
            ack_count <= ack_count + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] beat_data(input vec_t v, input int i);
        return v.dbase + v.dstep * 32'(i);
    endfunction

    function automatic logic [3:0] beat_sel(input vec_t v, input int i);
        return (i % 2 == 1) ? (v.sel ^ v.sel_x) : v.sel;
    endfunction

    // Issue one burst from a record and play the slave for it.
    // Entered and left at a falling edge.
    task automatic run_vec(input vec_t v, input int idx);
        int          nb;
        int          ack0;
        logic [31:0] exp_a;
        logic [31:0] exp_d;
        nb = (v.bl == 10'd0) ? 1 : int'(v.bl);
        for (int i = 0; i < nb; i++) begin
            adr_q.push_back(v.adr + 32'(4 * i));
            dat_q.push_back(beat_data(v, i));
        end
        ack0    = ack_count;
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
        m_we_i  = v.we;
        m_adr_i = v.adr;
        m_bl_i  = v.bl;
        m_dat_i = beat_data(v, 0);
        m_sel_i = beat_sel(v, 0);
        m_bry_i = 1'b1;
        @(negedge clk);
        m_stb_i = 1'b0;
        for (int b = 0; b < nb; b++) begin
            #1;
            exp_a = adr_q.pop_front();
            exp_d = dat_q.pop_front();
            check($sformatf("v%0d b%0d req_stb", idx, b), {31'd0, s_stb_o}, 32'd1);
            check($sformatf("v%0d b%0d req_ack", idx, b), {31'd0, m_ack_o}, 32'd0);
            check($sformatf("v%0d b%0d adr", idx, b), s_adr_o, exp_a);
            check($sformatf("v%0d b%0d we", idx, b), {31'd0, s_we_o}, {31'd0, v.we});
            if (v.we) begin
                check($sformatf("v%0d b%0d wdat", idx, b), s_dat_o, exp_d);
                check($sformatf("v%0d b%0d sel", idx, b), {28'd0, s_sel_o}, {28'd0, beat_sel(v, b)});
            end
            if (b == nb - 1) begin
                check($sformatf("v%0d last_adr", idx), s_adr_o, v.exp_last_adr);
            end
            for (int w = 0; w < v.wait_cyc; w++) begin
                @(negedge clk);
                #1;
                check($sformatf("v%0d b%0d wait%0d", idx, b, w), {30'd0, s_stb_o, m_ack_o}, 32'd2);
            end
            s_ack_i = 1'b1;
            s_dat_i = v.we ? ~exp_d : exp_d;
            @(negedge clk);
            s_ack_i = 1'b0;
            s_dat_i = 32'h0BAD_0BAD;
            if (b == v.stall_beat) begin
                m_bry_i = 1'b0;
                if (!v.we) begin
                    for (int s = 0; s < v.stall_len; s++) begin
                        #1;
                        check($sformatf("v%0d stall%0d ack", idx, s), {31'd0, m_ack_o}, 32'd0);
                        check($sformatf("v%0d stall%0d hold", idx, s), m_dat_o, exp_d);
                        check($sformatf("v%0d stall%0d cyc", idx, s), {30'd0, s_cyc_o, s_stb_o}, 32'd2);
                        @(negedge clk);
                    end
                    m_bry_i = 1'b1;
                end
            end
            if (b + 1 < nb) begin
                m_dat_i = beat_data(v, b + 1);
                m_sel_i = beat_sel(v, b + 1);
            end
            #1;
            if (!v.we) begin
                rd_hold = exp_d;
            end
            check($sformatf("v%0d b%0d m_ack", idx, b), {31'd0, m_ack_o}, 32'd1);
            check($sformatf("v%0d b%0d resp_cyc", idx, b), {30'd0, s_cyc_o, s_stb_o}, 32'd2);
            check($sformatf("v%0d b%0d m_dat", idx, b), m_dat_o, rd_hold);
            m_bry_i = 1'b1;
            @(negedge clk);
        end
        #1;
        check($sformatf("v%0d end_ctl", idx), {29'd0, s_cyc_o, s_stb_o, m_ack_o}, 32'd0);
        check($sformatf("v%0d ack_cnt", idx), 32'(ack_count - ack0), 32'(v.exp_beats));
        m_cyc_i = 1'b0;
        @(negedge clk);
    endtask

    // Hard stop if anything waits forever.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack0;
        int bad;

        vecs[0] = '{we:1'b0, adr:32'h0000_1000, bl:10'd0, wait_cyc:2, dbase:32'hDEAD_BEEF, dstep:32'd1,
                    sel:4'hF, sel_x:4'h0, stall_beat:-1, stall_len:0, exp_beats:1, exp_last_adr:32'h0000_1000};
        vecs[1] = '{we:1'b0, adr:32'h0000_2000, bl:10'd4, wait_cyc:0, dbase:32'hA000_0000, dstep:32'h10,
                    sel:4'hF, sel_x:4'h0, stall_beat:1, stall_len:3, exp_beats:4, exp_last_adr:32'h0000_200C};
        vecs[2] = '{we:1'b1, adr:32'h0000_3000, bl:10'd4, wait_cyc:1, dbase:32'h11, dstep:32'h11,
                    sel:4'hF, sel_x:4'h0, stall_beat:-1, stall_len:0, exp_beats:4, exp_last_adr:32'h0000_300C};
        vecs[3] = '{we:1'b0, adr:32'hFFFF_FFF8, bl:10'd3, wait_cyc:0, dbase:32'h1234_5678, dstep:32'h0101_0101,
                    sel:4'hF, sel_x:4'h0, stall_beat:-1, stall_len:0, exp_beats:3, exp_last_adr:32'h0000_0000};
        vecs[4] = '{we:1'b1, adr:32'h0000_0040, bl:10'd2, wait_cyc:3, dbase:32'hCAFE_0000, dstep:32'h101,
                    sel:4'h3, sel_x:4'hC, stall_beat:0, stall_len:2, exp_beats:2, exp_last_adr:32'h0000_0044};
        vecs[5] = '{we:1'b0, adr:32'h0000_0100, bl:10'd1, wait_cyc:5, dbase:32'h5A5A_A5A5, dstep:32'd0,
                    sel:4'hF, sel_x:4'h0, stall_beat:-1, stall_len:0, exp_beats:1, exp_last_adr:32'h0000_0100};

        // Reset state.
        #2;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst ctl", {26'd0, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, 1'b0}, 32'd0);
        check("rst s_adr", s_adr_o, 32'd0);
        check("rst m_dat", m_dat_o, 32'd0);
        check("rst s_dat", s_dat_o, 32'd0);
        check("rst s_sel", {28'd0, s_sel_o}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        // Abort in REQ of beat 2 of 8 with a slave ack in the same cycle.
        ack0    = ack_count;
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
        m_we_i  = 1'b0;
        m_adr_i = 32'h0000_5000;
        m_bl_i  = 10'd8;
        m_bry_i = 1'b1;
        @(negedge clk);
        m_stb_i = 1'b0;
        #1;
        check("abort b0 adr", s_adr_o, 32'h0000_5000);
        s_ack_i = 1'b1;
        s_dat_i = 32'h5000_0001;
        @(negedge clk);
        s_ack_i = 1'b0;
        #1;
        check("abort b0 ack", {31'd0, m_ack_o}, 32'd1);
        check("abort b0 dat", m_dat_o, 32'h5000_0001);
        @(negedge clk);
        #1;
        check("abort b1 adr", s_adr_o, 32'h0000_5004);
        check("abort b1 stb", {31'd0, s_stb_o}, 32'd1);
        m_cyc_i = 1'b0;
        s_ack_i = 1'b1;
        s_dat_i = 32'h5000_0002;
        #1;
        check("abort cycle ack", {31'd0, m_ack_o}, 32'd0);
        @(negedge clk);
        #1;
        check("abort idle ctl", {29'd0, s_cyc_o, s_stb_o, m_ack_o}, 32'd0);
        check("abort dat hold", m_dat_o, 32'h5000_0001);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("late ack%0d ctl", i), {29'd0, s_cyc_o, s_stb_o, m_ack_o}, 32'd0);
            check($sformatf("late ack%0d dat", i), m_dat_o, 32'h5000_0001);
        end
        s_ack_i = 1'b0;
        check("abort ack_cnt", 32'(ack_count - ack0), 32'd1);
        rd_hold = 32'h5000_0001;
        @(negedge clk);
        run_vec(vecs[0], 10);

        // Timeout: slave never acks; error pulse 256 cycles after stb rises.
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
        m_we_i  = 1'b0;
        m_adr_i = 32'h0000_6000;
        m_bl_i  = 10'd2;
        @(negedge clk);
        m_stb_i = 1'b0;
        bad = 0;
        for (int c = 1; c <= 256; c++) begin
            #1;
            if (!s_stb_o || !s_cyc_o || m_err_o) begin
                bad++;
            end
            @(negedge clk);
        end
        check("tmo req held", 32'(bad), 32'd0);
        #1;
        check("tmo err", {31'd0, m_err_o}, 32'd1);
        check("tmo ctl", {30'd0, s_cyc_o, s_stb_o}, 32'd0);
        @(negedge clk);
        #1;
        check("tmo err pulse", {31'd0, m_err_o}, 32'd0);
        m_cyc_i = 1'b0;
        @(negedge clk);

        // Reset asserted mid-REQ clears everything without a clock edge.
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
        m_we_i  = 1'b1;
        m_adr_i = 32'h0000_7000;
        m_bl_i  = 10'd4;
        m_dat_i = 32'h7777_7777;
        m_sel_i = 4'h9;
        @(negedge clk);
        m_stb_i = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("prerst stb", {31'd0, s_stb_o}, 32'd1);
        reset = 1'b1;
        #1;
        check("midrst ctl", {27'd0, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o}, 32'd0);
        check("midrst s_adr", s_adr_o, 32'd0);
        check("midrst m_dat", m_dat_o, 32'd0);
        check("midrst s_dat", s_dat_o, 32'd0);
        check("midrst s_sel", {28'd0, s_sel_o}, 32'd0);
        m_cyc_i = 1'b0;
        rd_hold = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_vec(vecs[2], 11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
